// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result path: widths, opcodes, capture entry and
// capture FSM state.
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND = 4'b0010;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0011;
    localparam logic [OP_W-1:0] OP_XOR = 4'b0100;
    localparam logic [OP_W-1:0] OP_NOT = 4'b0101;
    localparam logic [OP_W-1:0] OP_SHL = 4'b0110;
    localparam logic [OP_W-1:0] OP_SHR = 4'b0111;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic              acc;
        logic [DATA_W-1:0] data;
    } alu_entry_t;

    typedef enum logic [0:0] {
        WAIT_DONE,
        WAIT_LOW
    } cap_state_t;

    // Accumulate-mode operations report through the accumulator, others through results.
    function automatic logic [DATA_W-1:0] select_data(input logic              acc,
                                                      input logic [DATA_W-1:0] results,
                                                      input logic [DATA_W-1:0] accumulator);
        return acc ? accumulator : results;
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Synchronous first-word-fall-through FIFO of alu_entry_t. A push into a full FIFO is
// accepted only when a pop happens on the same edge.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  alu_entry_t       wdata,
    output alu_entry_t       rdata,
    output logic             accepted,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    alu_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        empty    = (count_q == '0);
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        accepted = push_ok;

        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/alu_result_collector.sv
// Captures one tagged entry per alu_done assertion and streams it out over valid/ready.
// ALU_COLLECT_STATS_EN adds saturating cap_total / drop_total counters.
module alu_result_collector #(
    parameter int unsigned DATA_W = alu_pkg::DATA_W,
    parameter int unsigned OP_W   = alu_pkg::OP_W,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] results,
    input  logic [DATA_W-1:0] accumulator,
    input  logic [OP_W-1:0]   op,
    input  logic              acc,
    output logic              cap_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OP_W-1:0]   out_op,
    output logic              out_acc,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
`ifdef ALU_COLLECT_STATS_EN
    ,
    output logic [15:0]       cap_total,
    output logic [7:0]        drop_total
`endif
);

    import alu_pkg::*;

    cap_state_t state_q, state_d;
    logic       overflow_q, overflow_d;
    logic       push_req, push_ok, full, empty;
    alu_entry_t wr_entry, head;

    always_comb begin
        state_d  = state_q;
        push_req = 1'b0;
        unique case (state_q)
            WAIT_DONE: begin
                if (alu_done) begin
                    push_req = 1'b1;
                    state_d  = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!alu_done) begin
                    state_d = WAIT_DONE;
                end
            end
            default: state_d = WAIT_DONE;
        endcase

        wr_entry.op   = op;
        wr_entry.acc  = acc;
        wr_entry.data = select_data(acc, results, accumulator);

        overflow_d = overflow_q | (push_req & ~push_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_DONE;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    alu_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_req),
        .pop      (out_ready),
        .wdata    (wr_entry),
        .rdata    (head),
        .accepted (push_ok),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    assign out_valid = ~empty;
    assign out_data  = head.data;
    assign out_op    = head.op;
    assign out_acc   = head.acc;
    assign cap_ready = ~full;
    assign overflow  = overflow_q;

`ifdef ALU_COLLECT_STATS_EN
    logic [15:0] cap_total_q, cap_total_d;
    logic [7:0]  drop_total_q, drop_total_d;

    always_comb begin
        cap_total_d  = cap_total_q;
        drop_total_d = drop_total_q;
        if (push_ok && cap_total_q != 16'hFFFF) begin
            cap_total_d = cap_total_q + 16'd1;
        end
        if (push_req && !push_ok && drop_total_q != 8'hFF) begin
            drop_total_d = drop_total_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_total_q  <= '0;
            drop_total_q <= '0;
        end else begin
            cap_total_q  <= cap_total_d;
            drop_total_q <= drop_total_d;
        end
    end

    assign cap_total  = cap_total_q;
    assign drop_total = drop_total_q;
`endif

endmodule

// File: tb/tb_alu_result_collector.sv
// Randomised and directed bench for alu_result_collector with a queue-based reference model
// and a negedge monitor comparing the DUT against it.
module tb_alu_result_collector;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       alu_done = 1'b0;
    logic [7:0] results = '0;
    logic [7:0] accumulator = '0;
    logic [3:0] op = '0;
    logic       acc = 1'b0;
    logic       out_ready = 1'b0;
    logic       cap_ready, out_valid, out_acc, overflow;
    logic [7:0] out_data;
    logic [3:0] out_op;
    logic [2:0] count;
`ifdef ALU_COLLECT_STATS_EN
    logic [15:0] cap_total;
    logic [7:0]  drop_total;
`endif

    always #5 clk = ~clk;

    alu_result_collector #(
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_done    (alu_done),
        .results     (results),
        .accumulator (accumulator),
        .op          (op),
        .acc         (acc),
        .cap_ready   (cap_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_op      (out_op),
        .out_acc     (out_acc),
        .count       (count),
        .overflow    (overflow)
`ifdef ALU_COLLECT_STATS_EN
        ,
        .cap_total   (cap_total),
        .drop_total  (drop_total)
`endif
    );

    typedef struct {
        logic [7:0] data;
        logic [3:0] op;
        logic       acc;
    } exp_t;

    exp_t ref_q[$];
    bit   prev_done = 1'b0;
    bit   exp_ovf = 1'b0;
    bit   armed = 1'b0;
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: one capture per rising alu_done, a bounded in-order queue, pops first.
    always @(posedge clk) begin
        if (rst) begin
            ref_q.delete();
            prev_done = 1'b0;
            exp_ovf   = 1'b0;
            armed     = 1'b1;
        end else if (armed) begin
            if (ref_q.size() != 0 && out_ready) begin
                void'(ref_q.pop_front());
            end
            if (alu_done && !prev_done) begin
                if (ref_q.size() < DEPTH) begin
                    ref_q.push_back('{data: acc ? accumulator : results, op: op, acc: acc});
                end else begin
                    exp_ovf = 1'b1;
                end
            end
            prev_done = alu_done;
        end
    end

    always @(negedge clk) begin
        if (armed && !rst) begin
            chk("out_valid", 32'(out_valid), 32'(ref_q.size() != 0));
            chk("count", 32'(count), 32'(ref_q.size()));
            chk("cap_ready", 32'(cap_ready), 32'(ref_q.size() < DEPTH));
            chk("overflow", 32'(overflow), 32'(exp_ovf));
            if (ref_q.size() != 0) begin
                chk("head_data", 32'(out_data), 32'(ref_q[0].data));
                chk("head_op", 32'(out_op), 32'(ref_q[0].op));
                chk("head_acc", 32'(out_acc), 32'(ref_q[0].acc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] d, input logic [3:0] o, input logic a);
        alu_done    = 1'b1;
        results     = d;
        accumulator = ~d;
        op          = o;
        acc         = a;
        tick();
        alu_done = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_cap_ready", 32'(cap_ready), 32'd1);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_op", 32'(out_op), 32'd0);

        pulse(8'h3C, 4'b0010, 1'b0);
        chk("single_count", 32'(count), 32'd1);
        chk("single_data", 32'(out_data), 32'h3C);
        chk("single_op", 32'(out_op), 32'h2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        alu_done    = 1'b1;
        acc         = 1'b1;
        accumulator = 8'hA5;
        results     = 8'h11;
        repeat (5) tick();
        alu_done = 1'b0;
        tick();
        chk("held_count", 32'(count), 32'd1);
        chk("held_data", 32'(out_data), 32'hA5);
        chk("held_acc", 32'(out_acc), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        for (int i = 1; i <= 4; i++) pulse(8'(i), 4'(i), 1'b0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_cap_ready", 32'(cap_ready), 32'd0);
        pulse(8'h05, 4'h5, 1'b0);
        chk("drop_overflow", 32'(overflow), 32'd1);
        chk("drop_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_data", 32'(out_data), 32'(i));
            tick();
        end
        chk("drained_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        do_reset();
        for (int i = 1; i <= 4; i++) pulse(8'(8'h10 + i), 4'h1, 1'b0);
        alu_done  = 1'b1;
        results   = 8'h55;
        acc       = 1'b0;
        out_ready = 1'b1;
        tick();
        alu_done  = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("pushpop_overflow", 32'(overflow), 32'd0);
        chk("pushpop_count", 32'(count), 32'd4);
        chk("pushpop_head", 32'(out_data), 32'h12);

        do_reset();
        for (int i = 0; i < 3; i++) pulse(8'(8'h20 + i), 4'h3, 1'b0);
        alu_done = 1'b1;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        alu_done = 1'b0;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        tick();
        chk("midrst_nocap", 32'(count), 32'd0);
        pulse(8'h77, 4'h6, 1'b0);
        chk("midrst_recap", 32'(count), 32'd1);

        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 199) == 0);
            alu_done    = ($urandom_range(0, 2) == 0);
            results     = 8'($urandom);
            accumulator = 8'($urandom);
            op          = 4'($urandom);
            acc         = 1'($urandom);
            out_ready   = ($urandom_range(0, 2) != 0);
            tick();
        end
        rst = 1'b0;
        alu_done = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
